// File: rtl/alt_mem_ddrx_buffer_pkg.sv
// Shared sizing helpers and types for the DDRx write-data buffer allocator.
package alt_mem_ddrx_buffer_pkg;

    function automatic int two_pow_N(input int n);
        return 1 << n;
    endfunction

    localparam int DEFAULT_BUFFER_ADDR_WIDTH = 6;
    localparam int CTL_BUFFER_DEPTH = two_pow_N(DEFAULT_BUFFER_ADDR_WIDTH);

    typedef logic [DEFAULT_BUFFER_ADDR_WIDTH-1:0] slot_addr_t;
    typedef logic [DEFAULT_BUFFER_ADDR_WIDTH:0]   slot_count_t;

endpackage

// File: rtl/alt_mem_ddrx_buffer_free_list.sv
// Circular register FIFO of free slot addresses, reset to 0..DEPTH-1 in order.
module alt_mem_ddrx_buffer_free_list
    import alt_mem_ddrx_buffer_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic          i_pop,
    output logic [AW-1:0] o_head,
    output logic [AW:0]   o_count
);

    localparam int DEPTH = two_pow_N(AW);
    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [AW:0]   C_ONE = (AW+1)'(1);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= AW'(i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= C_DEPTH;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_addr;
                r_tail        <= r_tail + A_ONE;
            end
            if (i_pop) begin
                r_head <= r_head + A_ONE;
            end
            if (i_push & ~i_pop) begin
                r_count <= r_count + C_ONE;
            end else if (~i_push & i_pop) begin
                r_count <= r_count - C_ONE;
            end
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/alt_mem_ddrx_buffer_allocator.sv
// Write-data buffer slot allocator with per-slot tracking and read pipeline.
// Define ALT_MEM_DDRX_BUFFER_ERR_CHECK_EN to enable sticky protocol error checks.
module alt_mem_ddrx_buffer_allocator
    import alt_mem_ddrx_buffer_pkg::*;
#(
    parameter int CFG_BUFFER_ADDR_WIDTH     = 6,
    parameter int CFG_ALMOST_FULL_THRESHOLD = 4,
    parameter int CFG_READ_LATENCY          = 1
) (
    input  logic                           ctl_clk,
    input  logic                           ctl_reset,
    input  logic                           writeif_valid,
    output logic                           writeif_ready,
    output logic [CFG_BUFFER_ADDR_WIDTH-1:0] writeif_address,
    input  logic                           writeif_address_blocked,
    output logic                           buffwrite_valid,
    output logic [CFG_BUFFER_ADDR_WIDTH-1:0] buffwrite_address,
    input  logic                           readif_valid,
    input  logic [CFG_BUFFER_ADDR_WIDTH-1:0] readif_address,
    input  logic                           readif_release,
    output logic                           buffread_valid,
    output logic [CFG_BUFFER_ADDR_WIDTH-1:0] buffread_address,
    output logic                           buffread_datavalid,
    output logic [CFG_BUFFER_ADDR_WIDTH:0]   occupancy,
    output logic                           almost_full,
    output logic                           err_release_invalid,
    output logic                           err_alloc_overflow
);

    localparam int AW    = CFG_BUFFER_ADDR_WIDTH;
    localparam int DEPTH = two_pow_N(AW);
    localparam int LAT   = CFG_READ_LATENCY;
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_THRESH = (AW+1)'(CFG_ALMOST_FULL_THRESHOLD);
    localparam logic [AW:0] C_ONE    = (AW+1)'(1);

    logic [AW:0]     r_occ;
    logic            r_afull;
    logic [LAT-1:0]  r_dv;

    logic [AW-1:0]   w_head;
    logic [AW:0]     w_free_cnt;
    logic [AW:0]     w_occ_nxt;
    logic            w_full;
    logic            w_accept;
    logic            w_rel_req;
    logic            w_rel_ok;

    // free count and occupancy always sum to DEPTH, so either can gate ready
    assign w_full        = (r_occ == C_DEPTH);
    assign writeif_ready = ~writeif_address_blocked & (w_free_cnt != '0);
    assign w_accept      = writeif_valid & writeif_ready;
    assign w_rel_req     = readif_valid & readif_release;

    alt_mem_ddrx_buffer_free_list #(
        .AW (AW)
    ) u_free_list (
        .i_clk       (ctl_clk),
        .i_rst       (ctl_reset),
        .i_push      (w_rel_ok),
        .i_push_addr (readif_address),
        .i_pop       (w_accept),
        .o_head      (w_head),
        .o_count     (w_free_cnt)
    );

`ifdef ALT_MEM_DDRX_BUFFER_ERR_CHECK_EN
    logic [DEPTH-1:0] r_valid;
    logic             r_err_rel;
    logic             r_err_ovf;

    // a slot that is not allocated is never pushed back, even if occupancy > 0
    assign w_rel_ok = w_rel_req & r_valid[readif_address];

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            r_valid   <= '0;
            r_err_rel <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_rel_ok) begin
                r_valid[readif_address] <= 1'b0;
            end
            if (w_accept) begin
                r_valid[w_head] <= 1'b1;
            end
            if (w_rel_req & ~r_valid[readif_address]) begin
                r_err_rel <= 1'b1;
            end
            if (writeif_valid & w_full & ~writeif_address_blocked) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign err_release_invalid = r_err_rel;
    assign err_alloc_overflow  = r_err_ovf;
`else
    assign w_rel_ok            = w_rel_req & (r_occ != '0);
    assign err_release_invalid = 1'b0;
    assign err_alloc_overflow  = 1'b0;
`endif

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_accept & ~w_rel_ok) begin
            w_occ_nxt = r_occ + C_ONE;
        end else if (~w_accept & w_rel_ok) begin
            w_occ_nxt = r_occ - C_ONE;
        end
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            r_occ   <= '0;
            r_afull <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_afull <= ((C_DEPTH - w_occ_nxt) <= C_THRESH);
        end
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            r_dv <= '0;
        end else begin
            r_dv[0] <= readif_valid;
            for (int i = 1; i < LAT; i++) begin
                r_dv[i] <= r_dv[i-1];
            end
        end
    end

    assign writeif_address    = w_head;
    assign buffwrite_valid    = w_accept;
    assign buffwrite_address  = w_head;
    assign buffread_valid     = readif_valid;
    assign buffread_address   = readif_address;
    assign buffread_datavalid = r_dv[LAT-1];
    assign occupancy          = r_occ;
    assign almost_full        = r_afull;

endmodule

// File: tb/tb_alt_mem_ddrx_buffer_allocator.sv
// Directed scoreboard bench for the write-data buffer allocator (AW=3, latency 3).
module tb_alt_mem_ddrx_buffer_allocator;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int THR   = 4;
    localparam int LAT   = 3;

    logic          ctl_clk = 1'b0;
    logic          ctl_reset;
    logic          writeif_valid;
    logic          writeif_ready;
    logic [AW-1:0] writeif_address;
    logic          writeif_address_blocked;
    logic          buffwrite_valid;
    logic [AW-1:0] buffwrite_address;
    logic          readif_valid;
    logic [AW-1:0] readif_address;
    logic          readif_release;
    logic          buffread_valid;
    logic [AW-1:0] buffread_address;
    logic          buffread_datavalid;
    logic [AW:0]   occupancy;
    logic          almost_full;
    logic          err_release_invalid;
    logic          err_alloc_overflow;

    int total = 0;
    int bad   = 0;
    int q_free[$];
    int m_occ;

    always #5 ctl_clk = ~ctl_clk;

    alt_mem_ddrx_buffer_allocator #(
        .CFG_BUFFER_ADDR_WIDTH     (AW),
        .CFG_ALMOST_FULL_THRESHOLD (THR),
        .CFG_READ_LATENCY          (LAT)
    ) dut (
        .ctl_clk                 (ctl_clk),
        .ctl_reset               (ctl_reset),
        .writeif_valid           (writeif_valid),
        .writeif_ready           (writeif_ready),
        .writeif_address         (writeif_address),
        .writeif_address_blocked (writeif_address_blocked),
        .buffwrite_valid         (buffwrite_valid),
        .buffwrite_address       (buffwrite_address),
        .readif_valid            (readif_valid),
        .readif_address          (readif_address),
        .readif_release          (readif_release),
        .buffread_valid          (buffread_valid),
        .buffread_address        (buffread_address),
        .buffread_datavalid      (buffread_datavalid),
        .occupancy               (occupancy),
        .almost_full             (almost_full),
        .err_release_invalid     (err_release_invalid),
        .err_alloc_overflow      (err_alloc_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic model_reset();
        q_free.delete();
        for (int i = 0; i < DEPTH; i++) q_free.push_back(i);
        m_occ = 0;
    endtask

    task automatic chk_occ(input string tag);
        chk({tag, "_occ"}, 32'(occupancy), m_occ);
        chk({tag, "_afull"}, 32'(almost_full), ((DEPTH - m_occ) <= THR) ? 1 : 0);
    endtask

    task automatic do_acc();
        int exp;
        writeif_valid = 1'b1;
        #1;
        exp = q_free.pop_front();
        chk("acc_ready", 32'(writeif_ready), 1);
        chk("acc_addr", 32'(writeif_address), exp);
        chk("acc_bwaddr", 32'(buffwrite_address), exp);
        tick();
        writeif_valid = 1'b0;
        m_occ++;
        chk_occ("acc");
    endtask

    task automatic do_rel(input int a);
        readif_valid   = 1'b1;
        readif_release = 1'b1;
        readif_address = AW'(a);
        tick();
        readif_valid   = 1'b0;
        readif_release = 1'b0;
        q_free.push_back(a);
        m_occ--;
        chk_occ("rel");
    endtask

    task automatic do_reset();
        ctl_reset = 1'b1;
        writeif_valid = 1'b0;
        writeif_address_blocked = 1'b0;
        readif_valid = 1'b0;
        readif_release = 1'b0;
        readif_address = '0;
        tick();
        tick();
        ctl_reset = 1'b0;
        model_reset();
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_ready", 32'(writeif_ready), 1);
        chk("rst_addr", 32'(writeif_address), 0);
        chk("rst_dv", 32'(buffread_datavalid), 0);
        chk("rst_err_rel", 32'(err_release_invalid), 0);
        chk("rst_err_ovf", 32'(err_alloc_overflow), 0);
        chk("rst_bwvalid", 32'(buffwrite_valid), 0);

        for (int i = 0; i < DEPTH; i++) do_acc();
        chk("full_ready", 32'(writeif_ready), 0);
        writeif_valid = 1'b1;
        #1;
        chk("full_bwvalid", 32'(buffwrite_valid), 0);
        tick();
        writeif_valid = 1'b0;
        chk_occ("full");
`ifdef ALT_MEM_DDRX_BUFFER_ERR_CHECK_EN
        chk("ovf_err", 32'(err_alloc_overflow), 1);
`else
        chk("ovf_err", 32'(err_alloc_overflow), 0);
`endif

        do_rel(5);
        do_acc();
        do_rel(2);
        do_rel(6);
        do_acc();
        do_acc();
        chk("refill_ready", 32'(writeif_ready), 0);

        #2;
        ctl_reset = 1'b1;
        #1;
        chk("arst_occ", 32'(occupancy), 0);
        chk("arst_ready", 32'(writeif_ready), 1);
        chk("arst_addr", 32'(writeif_address), 0);
        chk("arst_afull", 32'(almost_full), 0);
        tick();
        ctl_reset = 1'b0;
        model_reset();
        tick();

        for (int i = 0; i < 3; i++) do_acc();
        writeif_valid  = 1'b1;
        readif_valid   = 1'b1;
        readif_release = 1'b1;
        readif_address = 3'd1;
        #1;
        chk("both_addr", 32'(writeif_address), q_free.pop_front());
        chk("both_ready", 32'(writeif_ready), 1);
        tick();
        writeif_valid  = 1'b0;
        readif_valid   = 1'b0;
        readif_release = 1'b0;
        q_free.push_back(1);
        chk_occ("both");
        chk("both_next", 32'(writeif_address), q_free[0]);

        do_acc();
        do_acc();
        writeif_address_blocked = 1'b1;
        writeif_valid = 1'b1;
        #1;
        chk("blk_ready", 32'(writeif_ready), 0);
        chk("blk_bwvalid", 32'(buffwrite_valid), 0);
        tick();
        chk_occ("blk");
        chk("blk_addr", 32'(writeif_address), q_free[0]);
        writeif_address_blocked = 1'b0;
        writeif_valid = 1'b0;
        do_acc();

        repeat (4) tick();
        chk("rd_dv_idle", 32'(buffread_datavalid), 0);
        readif_valid   = 1'b1;
        readif_address = 3'd0;
        #1;
        chk("rd_bvalid", 32'(buffread_valid), 1);
        chk("rd_baddr", 32'(buffread_address), 0);
        tick();
        readif_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            chk($sformatf("rd_dv_%0d", k), 32'(buffread_datavalid), (k == LAT) ? 1 : 0);
            tick();
        end
        chk_occ("rd");

        do_acc();
        do_acc();
        chk("tail_full", 32'(writeif_ready), 0);

        do_reset();
        readif_valid   = 1'b1;
        readif_release = 1'b1;
        readif_address = 3'd7;
        tick();
        readif_valid   = 1'b0;
        readif_release = 1'b0;
        chk_occ("erel");
`ifdef ALT_MEM_DDRX_BUFFER_ERR_CHECK_EN
        chk("erel_flag", 32'(err_release_invalid), 1);
`else
        chk("erel_flag", 32'(err_release_invalid), 0);
`endif
        tick();
`ifdef ALT_MEM_DDRX_BUFFER_ERR_CHECK_EN
        chk("erel_sticky", 32'(err_release_invalid), 1);
`else
        chk("erel_sticky", 32'(err_release_invalid), 0);
`endif
        do_acc();
`ifdef ALT_MEM_DDRX_BUFFER_ERR_CHECK_EN
        readif_valid   = 1'b1;
        readif_release = 1'b1;
        readif_address = 3'd7;
        tick();
        readif_valid   = 1'b0;
        readif_release = 1'b0;
        chk_occ("erel_busy");
        chk("erel_busy_head", 32'(writeif_address), q_free[0]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
